// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU control codes for the ALU control decoder and the
// execute unit, plus the execute-unit FSM state type and a code classifier.
// No ports; imported with "import alu_ctrl_pkg::*;".
package alu_ctrl_pkg;

  localparam logic [5:0] ALU_SLL   = 6'b000000;
  localparam logic [5:0] ALU_SRL   = 6'b000010;
  localparam logic [5:0] ALU_SRA   = 6'b000011;
  localparam logic [5:0] ALU_SLLV  = 6'b000100;
  localparam logic [5:0] ALU_SRLV  = 6'b000110;
  localparam logic [5:0] ALU_SRAV  = 6'b000111;
  localparam logic [5:0] ALU_MFHI  = 6'b010000;
  localparam logic [5:0] ALU_MFLO  = 6'b010010;
  localparam logic [5:0] ALU_MULT  = 6'b011000;
  localparam logic [5:0] ALU_MULTU = 6'b011001;
  localparam logic [5:0] ALU_DIV   = 6'b011010;
  localparam logic [5:0] ALU_DIVU  = 6'b011011;
  localparam logic [5:0] ALU_ADD   = 6'b100000;
  localparam logic [5:0] ALU_ADDU  = 6'b100001;
  localparam logic [5:0] ALU_SUB   = 6'b100010;
  localparam logic [5:0] ALU_SUBU  = 6'b100011;
  localparam logic [5:0] ALU_AND   = 6'b100100;
  localparam logic [5:0] ALU_OR    = 6'b100101;
  localparam logic [5:0] ALU_XOR   = 6'b100110;
  localparam logic [5:0] ALU_NOR   = 6'b100111;
  localparam logic [5:0] ALU_SLT   = 6'b101010;
  localparam logic [5:0] ALU_SLTU  = 6'b101011;
  localparam logic [5:0] ALU_BEQ   = 6'b110000;
  localparam logic [5:0] ALU_BNE   = 6'b110001;
  localparam logic [5:0] ALU_BGTZ  = 6'b110010;
  localparam logic [5:0] ALU_BLEZ  = 6'b110011;
  localparam logic [5:0] ALU_LUI   = 6'b111000;

  typedef enum logic {
    ST_IDLE,
    ST_MULDIV
  } exec_state_e;

  function automatic logic is_muldiv(input logic [5:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU) ||
           (code == ALU_DIV)  || (code == ALU_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply / divide on operand magnitudes.
// Ports:
//   clk, rst_n          clock, async active-low reset (control state only)
//   start               latch operands and begin (one cycle)
//   is_div, is_signed   operation select
//   a, b                operands (dividend/divisor or multiplicand/multiplier)
//   done                one-cycle pulse; hi/lo valid in this cycle
//   hi, lo              sign-corrected result, valid while done=1
// The last iteration is not registered: hi/lo are formed from the final
// step combinationally so the owner can commit them on the done edge.
module muldiv_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic                   busy_p0;
  logic [CW-1:0]          cnt_p0;
  logic                   div_p0, qneg_p0, rneg_p0, bzero_p0;
  logic [WIDTH-1:0]       araw_p0, mc_p0;
  logic [2*WIDTH-1:0]     acc_p0, acc_fin;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]       a_mag, b_mag;

  // Multiply: acc = {partial, multiplier}, shift right with add.
  // Divide:   acc = {remainder, quotient}, restoring shift-subtract.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] acc_in,
                                              input logic [WIDTH-1:0]   mc,
                                              input logic               div);
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     part;
    acc = acc_in;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (div) begin
        part = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mc};
        if (!part[WIDTH]) acc = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else              acc = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        part = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : '0);
        acc  = {part, acc[WIDTH-1:1]};
      end
    end
    return acc;
  endfunction

  // Restore signs; division by zero returns all-ones quotient and the raw dividend.
  function automatic logic [2*WIDTH-1:0] fixup(input logic [2*WIDTH-1:0] acc,
                                               input logic div, input logic qneg,
                                               input logic rneg, input logic bzero,
                                               input logic [WIDTH-1:0] araw);
    logic [WIDTH-1:0] q, r;
    if (!div) return qneg ? -acc : acc;
    if (bzero) return {araw, {WIDTH{1'b1}}};
    q = acc[WIDTH-1:0];
    r = acc[2*WIDTH-1:WIDTH];
    return {(rneg ? -r : r), (qneg ? -q : q)};
  endfunction

  assign a_s   = $signed(a);
  assign b_s   = $signed(b);
  assign a_mag = (is_signed && a[WIDTH-1]) ? $unsigned(-a_s) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? $unsigned(-b_s) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_p0 <= 1'b0;
      cnt_p0  <= '0;
    end else if (start) begin
      busy_p0 <= 1'b1;
      cnt_p0  <= '0;
    end else if (busy_p0) begin
      if (cnt_p0 == LAST) busy_p0 <= 1'b0;
      else                cnt_p0  <= cnt_p0 + 1'b1;
    end
  end

  // Stage p0: operand latch and iteration accumulator
  always_ff @(posedge clk) begin
    if (start) begin
      div_p0   <= is_div;
      qneg_p0  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_p0  <= is_signed && a[WIDTH-1];
      bzero_p0 <= (b == '0);
      araw_p0  <= a;
      mc_p0    <= b_mag;
      acc_p0   <= {{WIDTH{1'b0}}, a_mag};
    end else if (busy_p0 && cnt_p0 != LAST) begin
      acc_p0   <= step(acc_p0, mc_p0, div_p0);
    end
  end

  assign acc_fin   = step(acc_p0, mc_p0, div_p0);
  assign done      = busy_p0 && (cnt_p0 == LAST);
  assign {hi, lo}  = fixup(acc_fin, div_p0, qneg_p0, rneg_p0, bzero_p0, araw_p0);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU driven by the 6-bit ALU control code.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operation handshake
//   ctrl, src_a, src_b    control code and operands
//   shamt                 immediate shift amount
//   out_valid / out_ready result handshake; outputs hold while stalled
//   result, taken, ovf, illegal  registered result and status
// Single-cycle ops register their result the cycle after accept; mult/div
// run in muldiv_iter and commit HI/LO with result=0 on completion.
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             taken,
  output logic             ovf,
  output logic             illegal
);

  exec_state_e             state_q, state_d;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sum_c, diff_c, res_c, hi_p0, lo_p0, md_hi, md_lo;
  logic                    taken_c, ovf_c, ill_c;
  logic                    accept, is_md, md_start, md_done;

  function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign a_s      = $signed(src_a);
  assign b_s      = $signed(src_b);
  assign sum_c    = src_a + src_b;
  assign diff_c   = src_a - src_b;
  assign in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_md    = is_muldiv(ctrl);
  assign md_start = accept && is_md;

  always_comb begin
    res_c   = '0;
    taken_c = 1'b0;
    ovf_c   = 1'b0;
    ill_c   = 1'b0;
    case (ctrl)
      ALU_SLL:  res_c = src_b << shamt;
      ALU_SRL:  res_c = src_b >> shamt;
      ALU_SRA:  res_c = $unsigned(b_s >>> shamt);
      ALU_SLLV: res_c = src_b << src_a[4:0];
      ALU_SRLV: res_c = src_b >> src_a[4:0];
      ALU_SRAV: res_c = $unsigned(b_s >>> src_a[4:0]);
      ALU_MFHI: res_c = hi_p0;
      ALU_MFLO: res_c = lo_p0;
      ALU_ADD:  begin res_c = sum_c;  ovf_c = add_ovf(src_a, src_b, sum_c);  end
      ALU_SUB:  begin res_c = diff_c; ovf_c = sub_ovf(src_a, src_b, diff_c); end
      ALU_ADDU: res_c = sum_c;
      ALU_SUBU: res_c = diff_c;
      ALU_AND:  res_c = src_a & src_b;
      ALU_OR:   res_c = src_a | src_b;
      ALU_XOR:  res_c = src_a ^ src_b;
      ALU_NOR:  res_c = ~(src_a | src_b);
      ALU_SLT:  res_c = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: res_c = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      ALU_LUI:  res_c = {src_b[15:0], {(WIDTH-16){1'b0}}};
      ALU_BEQ:  taken_c = (src_a == src_b);
      ALU_BNE:  taken_c = (src_a != src_b);
      ALU_BGTZ: taken_c = !src_a[WIDTH-1] && (src_a != '0);
      ALU_BLEZ: taken_c = src_a[WIDTH-1] || (src_a == '0);
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: ;
      default:  ill_c = 1'b1;
    endcase
  end

  muldiv_iter #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_start),
    .is_div    ((ctrl == ALU_DIV) || (ctrl == ALU_DIVU)),
    .is_signed ((ctrl == ALU_MULT) || (ctrl == ALU_DIV)),
    .a         (src_a),
    .b         (src_b),
    .done      (md_done),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (md_start) state_d = ST_MULDIV;
      ST_MULDIV: if (md_done)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Stage p0: registered outputs and the committed HI/LO pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      taken     <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      hi_p0     <= '0;
      lo_p0     <= '0;
    end else if (accept && !is_md) begin
      out_valid <= 1'b1;
      result    <= res_c;
      taken     <= taken_c;
      ovf       <= ovf_c;
      illegal   <= ill_c;
    end else if (md_start) begin
      out_valid <= 1'b0;
    end else if (md_done) begin
      out_valid <= 1'b1;
      result    <= '0;
      taken     <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      hi_p0     <= md_hi;
      lo_p0     <= md_lo;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  ctrl = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        taken, ovf, illegal;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  alu_exec_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .taken(taken), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
    logic [31:0] r;
    logic        tk;
    logic        ov;
    logic        il;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Issue one op with out_ready=1, return outputs at the first out_valid,
  // latency in cycles and how often in_ready was seen high while waiting.
  task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, output logic [31:0] r, output logic tk,
                        output logic ov, output logic il, output int lat, output int rdy_hi);
    int guard;
    @(negedge clk);
    ctrl = c; src_a = a; src_b = b; shamt = s; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++; failures++;
      $display("FAIL accept_timeout got=0 want=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_hi = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_hi++;
      @(posedge clk);
      #1;
      lat++;
    end
    r = result; tk = taken; ov = ovf; il = illegal;
  endtask

  // Reference model from the instruction semantics, using wide integer arithmetic.
  task automatic model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s, output logic [31:0] r, output logic tk,
                       output logic ov, output logic il, output int lat);
    longint sa, sb, v, d, q, rm;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; tk = 1'b0; ov = 1'b0; il = 1'b0; lat = 1;
    case (c)
      6'b000000: r = b << s;
      6'b000010: r = b >> s;
      6'b000100: r = b << a[4:0];
      6'b000110: r = b >> a[4:0];
      6'b000011, 6'b000111: begin
        d = longint'(1) << ((c == 6'b000011) ? s : a[4:0]);
        q = sb / d;
        if (sb < 0 && (sb % d) != 0) q = q - 1;
        r = q[31:0];
      end
      6'b010000: r = mhi;
      6'b010010: r = mlo;
      6'b100000: begin v = sa + sb; r = v[31:0]; ov = (v > 64'sd2147483647) || (v < -64'sd2147483648); end
      6'b100010: begin v = sa - sb; r = v[31:0]; ov = (v > 64'sd2147483647) || (v < -64'sd2147483648); end
      6'b100001: r = a + b;
      6'b100011: r = a - b;
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
      6'b101011: r = (a < b) ? 32'd1 : 32'd0;
      6'b111000: r = b * 32'd65536;
      6'b110000: tk = (a == b);
      6'b110001: tk = (a != b);
      6'b110010: tk = (sa > 0);
      6'b110011: tk = (sa <= 0);
      6'b011000: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; lat = 33; end
      6'b011001: begin p = {32'b0, a} * {32'b0, b}; mhi = p[63:32]; mlo = p[31:0]; lat = 33; end
      6'b011010, 6'b011011: begin
        lat = 33;
        if (b == 0) begin
          mlo = 32'hFFFF_FFFF; mhi = a;
        end else if (c == 6'b011010) begin
          q = sa / sb; rm = sa % sb; mlo = q[31:0]; mhi = rm[31:0];
        end else begin
          mlo = a / b; mhi = a % b;
        end
      end
      default: il = 1'b1;
    endcase
  endtask

  initial begin
    vec_t vt[$];
    logic [31:0] r, mr;
    logic tk, ov, il, mtk, mov, mil;
    int lat, rdy, mlat;
    logic [5:0] pool[27];
    logic [31:0] spec_vals[5];

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_taken", taken, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle vectors: {ctrl, a, b, shamt, result, taken, ovf, illegal}
    vt.push_back('{6'b100000, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
    vt.push_back('{6'b100001, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b000011, 32'h0, 32'hF000_0000, 5'd4, 32'hFF00_0000, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b101011, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b101010, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b101010, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b100010, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    vt.push_back('{6'b100011, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b000000, 32'h0, 32'h1, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b000110, 32'h24, 32'h8000_0000, 5'd0, 32'h0800_0000, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b000111, 32'h24, 32'h8000_0000, 5'd0, 32'hF800_0000, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b100111, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd0, 32'hF000_F000, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b100110, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b100100, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'h0F0F_0000, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b100101, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'hFFFF_0F0F, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b111000, 32'h0, 32'h0001_ABCD, 5'd0, 32'hABCD_0000, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b110000, 32'h5, 32'h5, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0});
    vt.push_back('{6'b110001, 32'h5, 32'h5, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b110010, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{6'b110010, 32'h1, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0});
    vt.push_back('{6'b110011, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0});
    vt.push_back('{6'b110011, 32'h8000_0000, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0});
    vt.push_back('{6'b111111, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{6'b000001, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1});
    foreach (vt[i]) begin
      run_op(vt[i].c, vt[i].a, vt[i].b, vt[i].s, r, tk, ov, il, lat, rdy);
      chk($sformatf("vec%0d_result", i), r, vt[i].r);
      chk($sformatf("vec%0d_taken", i), tk, vt[i].tk);
      chk($sformatf("vec%0d_ovf", i), ov, vt[i].ov);
      chk($sformatf("vec%0d_illegal", i), il, vt[i].il);
      chk($sformatf("vec%0d_latency", i), lat, 1);
    end

    // mult -3 * 5
    run_op(6'b011000, 32'hFFFF_FFFD, 32'd5, 5'd0, r, tk, ov, il, lat, rdy);
    chk("mult_latency", lat, 33);
    chk("mult_in_ready_busy", rdy, 0);
    chk("mult_result", r, 0);
    run_op(6'b010010, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("mult_lo", r, 32'hFFFF_FFF1);
    run_op(6'b010000, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("mult_hi", r, 32'hFFFF_FFFF);

    // div -7 / 2
    run_op(6'b011010, 32'hFFFF_FFF9, 32'd2, 5'd0, r, tk, ov, il, lat, rdy);
    chk("div_latency", lat, 33);
    run_op(6'b010010, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("div_lo", r, 32'hFFFF_FFFD);
    run_op(6'b010000, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("div_hi", r, 32'hFFFF_FFFF);

    // divu 9 / 0
    run_op(6'b011011, 32'd9, 32'd0, 5'd0, r, tk, ov, il, lat, rdy);
    run_op(6'b010010, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("divu0_lo", r, 32'hFFFF_FFFF);
    run_op(6'b010000, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("divu0_hi", r, 32'd9);

    // signed most-negative / -1
    run_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, r, tk, ov, il, lat, rdy);
    run_op(6'b010010, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("divmin_lo", r, 32'h8000_0000);
    run_op(6'b010000, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("divmin_hi", r, 32'h0);

    // Backpressure: hold an add result for 5 cycles, then release and accept
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    ctrl = 6'b100000; src_a = 32'd5; src_b = 32'd7; shamt = '0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    ctrl = 6'b100010; src_a = 32'd20; src_b = 32'd3;
    chk("bp_valid", out_valid, 1);
    chk("bp_result", result, 32'd12);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_result", k), result, 32'd12);
      chk($sformatf("bp_hold%0d_valid", k), out_valid, 1);
      chk($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_result", result, 32'd17);
    chk("bp_next_valid", out_valid, 1);

    // Reset in the middle of a divide
    @(negedge clk);
    ctrl = 6'b011010; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_taken", taken, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mhi = '0;
    mlo = '0;
    run_op(6'b010010, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("midrst_mflo", r, 0);
    run_op(6'b010000, 0, 0, 0, r, tk, ov, il, lat, rdy);
    chk("midrst_mfhi", r, 0);
    run_op(6'b111111, 32'hDEAD, 32'hBEEF, 0, r, tk, ov, il, lat, rdy);
    chk("midrst_illegal_flag", il, 1);
    chk("midrst_illegal_result", r, 0);

    // Randomized ops against the reference model
    pool = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
             6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
             6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
             6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b111000, 6'b110000,
             6'b110001, 6'b110010, 6'b110011};
    spec_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int n = 0; n < 300; n++) begin
      logic [5:0]  c;
      logic [31:0] a, b;
      logic [4:0]  s;
      c = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : pool[$urandom_range(0, 26)];
      a = ($urandom_range(0, 3) == 0) ? spec_vals[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? spec_vals[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      s = 5'($urandom_range(0, 31));
      model(c, a, b, s, mr, mtk, mov, mil, mlat);
      run_op(c, a, b, s, r, tk, ov, il, lat, rdy);
      chk($sformatf("rnd%0d_c%b_result", n, c), r, mr);
      chk($sformatf("rnd%0d_c%b_taken", n, c), tk, mtk);
      chk($sformatf("rnd%0d_c%b_ovf", n, c), ov, mov);
      chk($sformatf("rnd%0d_c%b_illegal", n, c), il, mil);
      chk($sformatf("rnd%0d_c%b_latency", n, c), lat, mlat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
